vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-006 SHALL have parameter SPLIT_X, default 320, split-mode boundary column.
REQ-007 SHALL have ports, clock and reset first:
clk_display  in  1  pixel clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  pixel-advance enable.
mode  in  2  pattern select: 0 split, 1 solid, 2 bars, 3 checker.
fg_rgb  in  24  foreground colour; [23:16] R, [15:8] G, [7:0] B.
bg_rgb  in  24  background colour, same packing.
hsync  out  1  horizontal sync.
vsync  out  1  vertical sync.
de  out  1  data enable, high in active area.
sx  out  12  current column.
sy  out  12  current line.
rgb  out  24  pixel colour.
line_start  out  1  one-cycle pulse at column 0 of every line.
frame_start  out  1  one-cycle pulse at pixel (0,0).
frame_cnt  out  16  completed-frame count.

Function
REQ-008 SHALL run h counter 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), advancing only on cycles with en=1.
REQ-009 SHALL wrap h to 0 after H_TOTAL-1 and advance v on the same cycle; v wraps to 0 after V_TOTAL-1.
REQ-010 SHALL assert hsync while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync by the same rule on v with V parameters.
REQ-011 SHALL assert de when h < H_ACTIVE and v < V_ACTIVE; rgb SHALL be 24'h000000 whenever de=0.
REQ-012 SHALL register all outputs; latency is exactly 1 cycle from counter value to hsync/vsync/de/sx/sy/rgb/pulses, all mutually aligned.
REQ-013 With en=0, counters and all outputs SHALL hold; line_start/frame_start SHALL be 0.
REQ-014 Mode 0: rgb = bg_rgb for sx < SPLIT_X, else fg_rgb.
REQ-015 Mode 1: rgb = fg_rgb over the whole active area.
REQ-016 Mode 2: 8 bars, each H_ACTIVE/8 wide, left to right white, yellow, cyan, green, magenta, red, blue, black; columns beyond 8*(H_ACTIVE/8) are black.
REQ-017 Mode 3: 32x32 checker; rgb = fg_rgb when sx[5] XOR sy[5] is 0, else bg_rgb.
REQ-018 mode SHALL be sampled only on the counter step to (0,0); a mid-frame change SHALL take effect at the next frame. fg_rgb/bg_rgb SHALL take effect immediately.
REQ-019 frame_cnt SHALL increment when frame_start pulses and wrap from 16'hFFFF to 0.

Reset
REQ-020 While rst_n=0: counters at 0; mode register = 0; hsync and vsync at inactive level (!SYNC_POL); de, line_start, frame_start at 0; sx, sy, rgb, frame_cnt at 0.
REQ-021 Reset mid-line/mid-frame SHALL abort immediately; the first en=1 cycle after release SHALL output pixel (0,0) with frame_start=1 and line_start=1.

Configuration
REQ-022 Macro VGA_FRAME_CNT_EN: when defined, frame_cnt SHALL behave per REQ-019; when undefined, frame_cnt SHALL be tied to 0 and no counter logic is built. The port exists in both builds.

Structure
REQ-023 Package vga_pkg SHALL hold the mode enum, default 640x480 timing constants, and the eight bar colour constants.
REQ-024 Sub-module vga_axis_counter (parametrised length, enable in, wrap pulse out) SHALL be instantiated once for h and once for v.

Verification
REQ-025 Reset, then en=1 with defaults -> hsync low for exactly 96 cycles; period 800 cycles; first low at 657th output cycle of a line.
REQ-026 Defaults, full frame -> vsync low for 2 lines (1600 cycles); frame period 420000 cycles; de high for 307200 cycles per frame.
REQ-027 mode=0, fg=FFFFFF, bg=000001 -> line 0 pixel 319 = 000001, pixel 320 = FFFFFF; porch pixels = 000000.
REQ-028 mode 0->2 at line 100 -> rest of frame stays split; next frame pixel 80 = FFFF00 (yellow bar).
REQ-029 en toggled 1-0-1 every cycle -> frame period 840000 cycles; outputs identical to the en=1 sequence with each value held 2 cycles.
REQ-030 rst_n pulsed at h=400, v=200 -> all outputs at reset values; after release, frame_start and line_start pulse on the first enabled cycle; frame_cnt=0 (macro on).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: pattern modes,
// default 640x480 timing and the colour-bar palette.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SPLIT   = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  // Default 640x480@60 timing, in pixels and lines.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Width of the column/line counters.
  localparam int CNT_W = 12;

  // Colour bars, left to right.
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..LEN-1 on enabled cycles and flags the step
// from LEN-1 back to 0 so the next axis can advance on the same edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LEN = 800
) (
  input  logic             clk_display,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  // Wrap is combinational so the downstream axis steps on this same edge.
  assign wrap = en && (cnt == LAST);

  // Position register: advance on enable, return to 0 after the last value.
  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator. Every output is registered one
// cycle after the raster position it describes, so sync, de, position,
// colour and pulses stay aligned. The pattern mode is latched only when
// the raster steps to (0,0); colours apply immediately.
// Optional feature: define VGA_FRAME_CNT_EN to build the completed-frame
// counter; otherwise frame_cnt is constant 0.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int SPLIT_X  = 320
) (
  input  logic        clk_display,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] fg_rgb,
  input  logic [23:0] bg_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] sx,
  output logic [11:0] sy,
  output logic [23:0] rgb,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_B  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_B  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] SPLIT_COL = CNT_W'(SPLIT_X);
  localparam logic [CNT_W-1:0] BARS_END  = CNT_W'(8 * BAR_W);
  localparam logic             SYNC_ON   = (SYNC_POL != 0);

  logic [CNT_W-1:0] h, v;
  logic             h_wrap, v_wrap;
  mode_e            mode_q;
  logic             de_nxt, hs_nxt, vs_nxt;
  logic [2:0]       bar_idx;
  logic [23:0]      pix;

  vga_axis_counter #(.LEN(H_TOTAL)) u_h_cnt (
    .clk_display (clk_display),
    .rst_n       (rst_n),
    .en          (en),
    .cnt         (h),
    .wrap        (h_wrap)
  );

  vga_axis_counter #(.LEN(V_TOTAL)) u_v_cnt (
    .clk_display (clk_display),
    .rst_n       (rst_n),
    .en          (h_wrap),
    .cnt         (v),
    .wrap        (v_wrap)
  );

  // Latch the requested pattern only on the step into a new frame.
  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SPLIT;
    end else if (v_wrap) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Raster-region decode for the current counter position.
  always_comb begin
    de_nxt = (h < H_ACT_END) && (v < V_ACT_END);
    hs_nxt = (h >= H_SYNC_B) && (h < H_SYNC_E);
    vs_nxt = (v >= V_SYNC_B) && (v < V_SYNC_E);
  end

  // Bar index: smallest bar whose right edge lies beyond the column.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (h < CNT_W'((i + 1) * BAR_W)) bar_idx = 3'(i);
    end
  end

  // Pattern colour for the current column/line under the latched mode.
  always_comb begin
    pix = COL_BLACK;
    case (mode_q)
      MODE_SPLIT:   pix = (h < SPLIT_COL) ? bg_rgb : fg_rgb;
      MODE_SOLID:   pix = fg_rgb;
      MODE_BARS:    pix = (h < BARS_END) ? bar_colour(bar_idx) : COL_BLACK;
      MODE_CHECKER: pix = (h[5] ^ v[5]) ? bg_rgb : fg_rgb;
      default:      pix = COL_BLACK;
    endcase
  end

  // Output register: capture on enabled cycles, hold otherwise (pulses drop).
  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      rgb         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= hs_nxt ? SYNC_ON : ~SYNC_ON;
      vsync       <= vs_nxt ? SYNC_ON : ~SYNC_ON;
      de          <= de_nxt;
      sx          <= h;
      sy          <= v;
      rgb         <= de_nxt ? pix : COL_BLACK;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic started;

  // Count frames completed since reset; the first frame_start after reset
  // only marks the beginning, each later one closes a frame.
  always_ff @(posedge clk_display or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      started   <= 1'b0;
    end else if (en && (h == '0) && (v == '0)) begin
      if (started) frame_cnt <= frame_cnt + 16'd1;
      started <= 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen using a reduced raster (68x40 active) so full
// frames are short. A behavioural model derives every expected output from
// the count of enabled cycles since reset.
module tb_vga_pattern_gen;

  localparam int HA  = 68;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 40;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int SPLIT = 20;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FL = HT * VT;
  localparam logic POL = 1'b0;

  // Clock and reset
  logic clk_display = 1'b0;
  always #5 clk_display = ~clk_display;

  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] fg_rgb = 24'hFFFFFF;
  logic [23:0] bg_rgb = 24'h000001;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [11:0] sx, sy;
  logic [23:0] rgb;
  logic [15:0] frame_cnt;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .SPLIT_X(SPLIT)
  ) dut (
    .clk_display (clk_display),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .fg_rgb      (fg_rgb),
    .bg_rgb      (bg_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .sx          (sx),
    .sy          (sy),
    .rgb         (rgb),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] sx;
    logic [11:0] sy;
    logic [23:0] rgb;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;
  } obs_t;

  // Spot-check vectors: pattern mode active in the frame, pixel, colour.
  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] bar_tab [8];

  int   checks = 0;
  int   errors = 0;
  int   k;
  logic [1:0] cur_mode, pending_mode;
  obs_t exp_o;
  int   cyc = 0;
  int   fs_prev = -1, fs_last = -1;
  int   hs_low, vs_low, de_cnt, first_hs, mark_cyc, table_hits;

  function automatic obs_t obs();
    obs_t o;
    o.hsync = hsync; o.vsync = vsync; o.de = de; o.sx = sx; o.sy = sy;
    o.rgb = rgb; o.line_start = line_start; o.frame_start = frame_start;
    o.frame_cnt = frame_cnt;
    return o;
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.hsync = ~POL;
    o.vsync = ~POL;
    return o;
  endfunction

  // Behavioural model: output for the kk-th enabled cycle since reset.
  function automatic obs_t model(input int kk, input logic [1:0] m,
                                 input logic [23:0] fg, input logic [23:0] bg);
    obs_t o;
    int p, x, y, f, b;
    p = kk % FL; x = p % HT; y = p / HT; f = kk / FL;
    o = '0;
    o.hsync = (x >= HA + HFP && x < HA + HFP + HS) ? POL : ~POL;
    o.vsync = (y >= VA + VFP && y < VA + VFP + VS) ? POL : ~POL;
    o.de = (x < HA) && (y < VA);
    o.sx = 12'(x);
    o.sy = 12'(y);
    o.line_start = (x == 0);
    o.frame_start = (p == 0);
`ifdef VGA_FRAME_CNT_EN
    o.frame_cnt = 16'(f);
`else
    o.frame_cnt = 16'd0;
`endif
    if (o.de) begin
      case (m)
        2'd0: o.rgb = (x < SPLIT) ? bg : fg;
        2'd1: o.rgb = fg;
        2'd2: begin
          b = x / (HA / 8);
          o.rgb = (b < 8) ? bar_tab[b] : 24'h000000;
        end
        default: o.rgb = (((x / 32) + (y / 32)) % 2 == 0) ? fg : bg;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: k=%0d got=%h expected=%h", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; cur_mode = 2'd0; pending_mode = 2'd0; exp_o = rst_obs();
  endtask

  task automatic mark();
    hs_low = 0; vs_low = 0; de_cnt = 0; first_hs = -1; mark_cyc = cyc;
  endtask

  // Driver: apply one cycle of inputs, advance the model, compare everything.
  task automatic tick(input logic e, input logic [1:0] m);
    int p;
    en = e; mode = m;
    @(posedge clk_display);
    if (e) begin
      p = k % FL;
      if (p == 0 && k > 0) cur_mode = pending_mode;
      exp_o = model(k, cur_mode, fg_rgb, bg_rgb);
      if (p == FL - 1) pending_mode = m;
      k++;
    end else begin
      exp_o.line_start = 1'b0;
      exp_o.frame_start = 1'b0;
    end
    #1;
    check("cycle", obs(), exp_o);
    if (frame_start) begin fs_prev = fs_last; fs_last = cyc; end
    if (e) begin
      hs_low += (hsync == POL) ? 1 : 0;
      vs_low += (vsync == POL) ? 1 : 0;
      de_cnt += de ? 1 : 0;
      if (hsync == POL && first_hs < 0) first_hs = cyc - mark_cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    mode = 2'($urandom_range(0, 3));
    repeat (2) @(posedge clk_display);
    #1;
    check("reset_values", obs(), rst_obs());
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic scan_table();
    foreach (vecs[i]) begin
      if (vecs[i].mode == cur_mode && int'(exp_o.sx) == vecs[i].x &&
          int'(exp_o.sy) == vecs[i].y) begin
        table_hits++;
        check_int("table_rgb", int'(rgb), int'(vecs[i].exp));
      end
    end
  endtask

  // mode input takes m_first for half the frame, then m_second
  task automatic run_frame(input logic [1:0] m_first, input logic [1:0] m_second);
    for (int i = 0; i < FL; i++) begin
      tick(1'b1, (i < FL / 2) ? m_first : m_second);
      scan_table();
    end
  endtask

  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF;
    bar_tab[3] = 24'h00FF00; bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    // fg = FFFFFF, bg = 000001 throughout the table frames
    vecs.push_back(vec_t'{2'd0, 19, 0, 24'h000001});
    vecs.push_back(vec_t'{2'd0, 20, 0, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd0, 67, 39, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd0, 68, 0, 24'h000000});
    vecs.push_back(vec_t'{2'd0, 0, 40, 24'h000000});
    vecs.push_back(vec_t'{2'd2, 0, 0, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd2, 8, 5, 24'hFFFF00});
    vecs.push_back(vec_t'{2'd2, 16, 5, 24'h00FFFF});
    vecs.push_back(vec_t'{2'd2, 31, 5, 24'h00FF00});
    vecs.push_back(vec_t'{2'd2, 32, 5, 24'hFF00FF});
    vecs.push_back(vec_t'{2'd2, 47, 5, 24'hFF0000});
    vecs.push_back(vec_t'{2'd2, 48, 5, 24'h0000FF});
    vecs.push_back(vec_t'{2'd2, 64, 5, 24'h000000});
    vecs.push_back(vec_t'{2'd1, 5, 5, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd1, 70, 5, 24'h000000});
    vecs.push_back(vec_t'{2'd3, 0, 0, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd3, 32, 0, 24'h000001});
    vecs.push_back(vec_t'{2'd3, 32, 32, 24'hFFFFFF});
    vecs.push_back(vec_t'{2'd3, 5, 33, 24'h000001});
    table_hits = 0;

    // Guarantee a falling reset edge at start-up.
    #2;
    model_reset();
    do_reset();

    // Frame 0 is split (reset mode); mode request changes mid-frame 1 -> 2,
    // so frame 1 shows bars, then solid, then checker.
    mark();
    run_frame(2'd1, 2'd2);
    check_int("hsync_low_per_frame", hs_low, HS * VT);
    check_int("hsync_first_low_idx", first_hs, HA + HFP);
    check_int("vsync_low_cycles", vs_low, VS * HT);
    check_int("de_cycles", de_cnt, HA * VA);
    run_frame(2'd1, 2'd1);
    check_int("frame_period", fs_last - fs_prev, FL);
    run_frame(2'd3, 2'd3);
    run_frame(2'd0, 2'd0);
    check_int("table_hits", table_hits, vecs.size());

    // en toggled 1-0-1: frame period doubles.
    do_reset();
    fs_prev = -1; fs_last = -1;
    for (int c = 0; c < 2 * FL + 4; c++) tick((c % 2) == 0, 2'd0);
    check_int("toggle_frame_period", fs_last - fs_prev, 2 * FL);

    // Randomised enable, mode and colours against the model.
    do_reset();
    for (int c = 0; c < 30000 && k < 3 * FL + 20; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        fg_rgb = 24'($urandom);
        bg_rgb = 24'($urandom);
      end
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    end
    check_int("random_progress", (k >= 3 * FL + 20) ? 1 : 0, 1);

    // Asynchronous reset in the middle of a line and frame.
    fg_rgb = 24'hFFFFFF; bg_rgb = 24'h000001;
    do_reset();
    for (int i = 0; i < 20 * HT + 41; i++) tick(1'b1, 2'd3);
    rst_n = 1'b0;
    #2;
    check("async_reset", obs(), rst_obs());
    @(posedge clk_display);
    #1;
    check("reset_hold", obs(), rst_obs());
    rst_n = 1'b1;
    model_reset();
    tick(1'b1, 2'd0);
    check_int("release_frame_start", int'(frame_start), 1);
    check_int("release_line_start", int'(line_start), 1);
    check_int("release_frame_cnt", int'(frame_cnt), 0);
    tick(1'b0, 2'd0);
    check_int("hold_pulse_clear", int'(line_start), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
